// File: rtl/operand_fetch_pkg.sv
// Purpose: ISA definitions and instruction decoder shared by the operand-fetch stage.
// Latency: pure definitions and combinational helper, no state.
// Backpressure: not applicable.
package operand_fetch_pkg;

    // Instruction field bit positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    // Decoded view of one instruction word
    typedef struct packed {
        logic        is_alu;      // produces an ALU transfer
        logic        is_illegal;  // undefined opcode
        logic        use_imm;     // operand2 comes from imm6 instead of rs2
        logic [3:0]  operation;
        logic [2:0]  dest;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;         // sign-extended imm6
    } dec_t;

    function automatic dec_t decode_instr(input logic [15:0] word);
        dec_t d;
        d           = '0;
        d.dest      = word[RD_MSB:RD_LSB];
        d.rs1       = word[RS1_MSB:RS1_LSB];
        d.rs2       = word[RS2_MSB:RS2_LSB];
        d.imm       = {{10{word[IMM_MSB]}}, word[IMM_MSB:IMM_LSB]};
        case (word[OPC_MSB:OPC_LSB])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                // Register-register ops pass the opcode straight through as the ALU code
                d.is_alu    = 1'b1;
                d.operation = word[OPC_MSB:OPC_LSB];
            end
            OP_ADDI: begin
                d.is_alu    = 1'b1;
                d.use_imm   = 1'b1;
                d.operation = ALU_ADD;
            end
            OP_NOP: begin
                d.is_alu    = 1'b0;
            end
            default: begin
                d.is_illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Purpose: 8x16 register file, two asynchronous read ports, one synchronous write port.
// Latency: reads combinational; write visible to reads the cycle after the write edge.
// Backpressure: none, the write port is taken every cycle it is enabled.
module reg_file #(
    parameter bit ZERO_REG     = 1'b1,
    parameter bit RESET_CLR_RF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  raddr1,
    output logic [15:0] rdata1,
    input  logic [2:0]  raddr2,
    output logic [15:0] rdata2,
    input  logic        wen,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] mem [8];
    logic        wen_eff;

    // With a hard-wired zero register, writes to r0 are dropped here
    assign wen_eff = wen && !(ZERO_REG && (waddr == 3'd0));

    generate
        if (RESET_CLR_RF) begin : g_clr
            // Storage with asynchronous clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 8; i++) begin
                        mem[i] <= 16'h0000;
                    end
                end else if (wen_eff) begin
                    mem[waddr] <= wdata;
                end
            end
        end else begin : g_noclr
            // Storage without reset: contents undefined until written
            always_ff @(posedge clk) begin
                if (wen_eff) begin
                    mem[waddr] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata1 = (ZERO_REG && (raddr1 == 3'd0)) ? 16'h0000 : mem[raddr1];
    assign rdata2 = (ZERO_REG && (raddr2 == 3'd0)) ? 16'h0000 : mem[raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Purpose: decode one instruction, fetch operands (with writeback bypass) and present them to the ALU.
// Latency: one cycle from instruction acceptance to alu_valid.
// Backpressure: single output register; instr_ready = !alu_valid || alu_ready, outputs hold while stalled.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter bit ZERO_REG     = 1'b1,
    parameter bit RESET_CLR_RF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] operand1,
    output logic [15:0] operand2,
    output logic [3:0]  operation,
    output logic [2:0]  dest,
    output logic        alu_valid,
    input  logic        alu_ready,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        illegal_op
);

    dec_t        dec;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        accept;
    logic        load;

    assign dec = decode_instr(instr);

    reg_file #(
        .ZERO_REG     (ZERO_REG),
        .RESET_CLR_RF (RESET_CLR_RF)
    ) u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (dec.rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (dec.rs2),
        .rdata2 (rf_rdata2),
        .wen    (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // Bypass: a same-cycle writeback overrides the stored value, except for a hard-wired r0
    always_comb begin
        src1 = rf_rdata1;
        src2 = rf_rdata2;
        if (ZERO_REG && (dec.rs1 == 3'd0)) begin
            src1 = 16'h0000;
        end else if (wb_en && (wb_addr == dec.rs1)) begin
            src1 = wb_data;
        end
        if (dec.use_imm) begin
            src2 = dec.imm;
        end else if (ZERO_REG && (dec.rs2 == 3'd0)) begin
            src2 = 16'h0000;
        end else if (wb_en && (wb_addr == dec.rs2)) begin
            src2 = wb_data;
        end
    end

    // NOPs and illegal opcodes are still accepted so they drain from the issuer
    assign instr_ready = !alu_valid || alu_ready;
    assign accept      = instr_valid && instr_ready;
    assign load        = accept && dec.is_alu;

    // Output register: loads on an accepted ALU op, drops valid once the ALU takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid <= 1'b0;
            operand1  <= 16'h0000;
            operand2  <= 16'h0000;
            operation <= 4'h0;
            dest      <= 3'h0;
        end else if (load) begin
            alu_valid <= 1'b1;
            operand1  <= src1;
            operand2  <= src2;
            operation <= dec.operation;
            dest      <= dec.dest;
        end else if (alu_ready) begin
            alu_valid <= 1'b0;
        end
    end

    // One-cycle pulse following acceptance of an undefined opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= accept && dec.is_illegal;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Purpose: scoreboard bench for operand_fetch with directed cases and randomized traffic.
// Latency: expectations are queued at acceptance and popped by the monitor on each ALU transfer.
// Backpressure: alu_ready is randomized; outputs are checked for stability while stalled.
module tb_operand_fetch;

    typedef struct {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  operation;
        logic [2:0]  dest;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic [3:0]  operation;
    logic [2:0]  dest;
    logic        alu_valid;
    logic        alu_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal_op;

    int vectors;
    int miscompares;

    // Reference model state
    logic [15:0] regs [8];
    exp_t        sb [$];
    logic        m_vld;
    logic        m_ill;

    // Monitor state
    exp_t        mon_e;
    logic        prev_stall;
    logic [15:0] prev_op1;
    logic [15:0] prev_op2;
    logic [3:0]  prev_oper;
    logic [2:0]  prev_dest;

    operand_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .operand1    (operand1),
        .operand2    (operand2),
        .operation   (operation),
        .dest        (dest),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] rd, input logic [2:0] rs1,
                                          input logic [5:0] imm);
        return {4'b1000, rd, rs1, imm};
    endfunction

    // Register value as seen in the accept cycle: r0 is zero, else writeback wins over storage
    function automatic logic [15:0] rd_val(input logic [2:0] idx, input logic we,
                                           input logic [2:0] wa, input logic [15:0] wd);
        if (idx == 3'd0) return 16'h0000;
        if (we && wa == idx) return wd;
        return regs[idx];
    endfunction

    task automatic model_reset();
        sb.delete();
        m_vld = 1'b0;
        m_ill = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    endtask

    // One clock cycle of stimulus; inputs change just after a rising edge
    task automatic cycle(input logic [15:0] ins, input logic iv, input logic ar,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         output logic acc);
        exp_t       e;
        logic       alu_op;
        logic       ill;
        logic       rdy;
        logic [3:0] opc;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [5:0] imm;
        instr       = ins;
        instr_valid = iv;
        alu_ready   = ar;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        @(negedge clk);
        rdy = !m_vld || ar;
        chk("instr_ready", {31'b0, instr_ready}, {31'b0, rdy});
        chk("alu_valid", {31'b0, alu_valid}, {31'b0, m_vld});
        chk("illegal_op", {31'b0, illegal_op}, {31'b0, m_ill});
        acc = iv && rdy;
        opc = ins[15:12];
        r1  = ins[8:6];
        r2  = ins[5:3];
        imm = ins[5:0];
        alu_op = 1'b0;
        ill    = 1'b0;
        e.op1       = rd_val(r1, we, wa, wd);
        e.op2       = rd_val(r2, we, wa, wd);
        e.operation = opc;
        e.dest      = ins[11:9];
        if (opc <= 4'd4) begin
            alu_op = 1'b1;
        end else if (opc == 4'd8) begin
            alu_op      = 1'b1;
            e.operation = 4'd0;
            e.op2       = 16'(signed'(imm));
        end else if (opc != 4'd15) begin
            ill = 1'b1;
        end
        @(posedge clk);
        if (acc && alu_op) begin
            sb.push_back(e);
            m_vld = 1'b1;
        end else if (ar) begin
            m_vld = 1'b0;
        end
        m_ill = acc && ill;
        if (we && wa != 3'd0) regs[wa] = wd;
        #1;
    endtask

    // Monitor: pops the scoreboard on every ALU transfer and checks hold-while-stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_operand1", {16'b0, operand1}, {16'b0, prev_op1});
                chk("stall_operand2", {16'b0, operand2}, {16'b0, prev_op2});
                chk("stall_operation", {28'b0, operation}, {28'b0, prev_oper});
                chk("stall_dest", {29'b0, dest}, {29'b0, prev_dest});
            end
            if (alu_valid && alu_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_transfer", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("operand1", {16'b0, operand1}, {16'b0, mon_e.op1});
                    chk("operand2", {16'b0, operand2}, {16'b0, mon_e.op2});
                    chk("operation", {28'b0, operation}, {28'b0, mon_e.operation});
                    chk("dest", {29'b0, dest}, {29'b0, mon_e.dest});
                end
            end
            prev_stall = alu_valid && !alu_ready;
            prev_op1   = operand1;
            prev_op2   = operand2;
            prev_oper  = operation;
            prev_dest  = dest;
        end
    end

    // Time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_alu_valid"}, {31'b0, alu_valid}, 32'd0);
        chk({tag, "_illegal_op"}, {31'b0, illegal_op}, 32'd0);
        chk({tag, "_operand1"}, {16'b0, operand1}, 32'd0);
        chk({tag, "_operand2"}, {16'b0, operand2}, 32'd0);
        chk({tag, "_operation"}, {28'b0, operation}, 32'd0);
        chk({tag, "_dest"}, {29'b0, dest}, 32'd0);
        chk({tag, "_instr_ready"}, {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        logic        acc;
        logic [15:0] cur;
        logic        cur_v;
        logic        pend;
        logic [3:0]  legal_ops [6];
        logic [3:0]  opc;
        int          r;
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
        vectors = 0;
        miscompares = 0;
        prev_stall = 1'b0;
        rst_n = 1'b0;
        instr = 16'h0;
        instr_valid = 1'b0;
        alu_ready = 1'b0;
        wb_en = 1'b0;
        wb_addr = 3'd0;
        wb_data = 16'h0;
        model_reset();
        #3;
        check_zero_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Writes then ADD r3 = r1 + r2
        cycle(16'h0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0005, acc);
        cycle(16'h0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0003, acc);
        cycle(enc_r(4'd0, 3'd3, 3'd1, 3'd2), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        // ADDI with negative and positive immediates
        cycle(enc_i(3'd4, 3'd1, 6'b111110), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        cycle(enc_i(3'd5, 3'd1, 6'b011111), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        // Accept-cycle bypass on both operands
        cycle(enc_r(4'd4, 3'd6, 3'd2, 3'd2), 1'b1, 1'b1, 1'b1, 3'd2, 16'hBEEF, acc);
        // Zero register: stored write dropped, bypass to r0 ignored
        cycle(16'h0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h1234, acc);
        cycle(enc_r(4'd3, 3'd1, 3'd0, 3'd2), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        cycle(enc_r(4'd3, 3'd1, 3'd0, 3'd0), 1'b1, 1'b1, 1'b1, 3'd0, 16'h5555, acc);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        // Backpressure: op A accepted, op B refused for three stalled cycles, then both drain
        cycle(enc_r(4'd1, 3'd7, 3'd1, 3'd2), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, acc);
        for (int i = 0; i < 3; i++) begin
            cycle(enc_r(4'd2, 3'd6, 3'd6, 3'd1), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, acc);
            chk("stalled_accept", {31'b0, acc}, 32'd0);
        end
        cycle(enc_r(4'd2, 3'd6, 3'd6, 3'd1), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        chk("resume_accept", {31'b0, acc}, 32'd1);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        // Illegal opcode and NOP
        cycle(16'h5ABC, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        cycle(16'hF123, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        cycle(16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        // Reset in the middle of a stall
        cycle(enc_r(4'd0, 3'd2, 3'd1, 3'd1), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, acc);
        cycle(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, acc);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midstall_reset");
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic; an offered instruction is held until accepted
        pend = 1'b0;
        cur = 16'h0;
        cur_v = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend) begin
                r = $urandom_range(0, 9);
                if (r <= 5) opc = legal_ops[$urandom_range(0, 5)];
                else if (r == 6) opc = 4'd15;
                else begin
                    opc = 4'($urandom_range(5, 14));
                    if (opc == 4'd8) opc = 4'd5;
                end
                cur   = {opc, 12'($urandom())};
                cur_v = ($urandom_range(0, 3) != 0);
            end
            cycle(cur, cur_v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)), 16'($urandom()), acc);
            pend = cur_v && !acc;
        end
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0, acc);
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
